// File: rtl/dcache_nway_if.sv
// Datapath and memory-controller signal bundle for dcache_nway.
interface dcache_nway_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        dwait;
  logic [31:0] dload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;

  // Cache side
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, hit_count, miss_count, dREN, dWEN, daddr, dstore
  );

  // Datapath / memory side
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, hit_count, miss_count, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_nway.sv
// Parametrised write-back, write-allocate, true-LRU data cache with flush sequencer.
module dcache_nway #(
  parameter int unsigned NSETS  = 8,
  parameter int unsigned NWAYS  = 2,
  parameter int unsigned NWORDS = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  dcache_nway_if.slave  cif
);
  localparam int unsigned IX  = $clog2(NSETS);
  localparam int unsigned BO  = $clog2(NWORDS);
  localparam int unsigned TW  = 30 - BO - IX;
  localparam int unsigned WW  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int unsigned AW  = WW;
  localparam int unsigned BW  = (NWORDS > 1) ? BO : 1;
  localparam int unsigned IXS = 2 + BO;
  localparam int unsigned TGS = 2 + BO + IX;

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;

  state_t state, state_n;

  logic          valid_q [NSETS][NWAYS];
  logic          dirty_q [NSETS][NWAYS];
  logic [TW-1:0] tag_q   [NSETS][NWAYS];
  logic [AW-1:0] age_q   [NSETS][NWAYS];
  logic [31:0]   data_q  [NSETS][NWAYS][NWORDS];

  logic [BW-1:0] w_q;
  logic [WW-1:0] vic_q;
  logic [IX-1:0] fset_q;
  logic [WW-1:0] fway_q;
  logic          refill_q;
  logic [31:0]   hit_cnt_q;
  logic [31:0]   miss_cnt_q;

  logic [TW-1:0] req_tag;
  logic [IX-1:0] req_ix;
  logic [BW-1:0] req_w;
  logic          req;
  logic          hit;
  logic [WW-1:0] hit_way;
  logic          vic_found;
  logic [WW-1:0] vic_way;
  logic          w_last;
  logic          line_last;
  logic          fl_dirty;
  logic          dhit_c;
  logic          dren_c;
  logic          dwen_c;
  logic [31:0]   daddr_c;
  logic [31:0]   dstore_c;

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [IX-1:0] s,
                                          input logic [BW-1:0] w);
    mk_addr = (32'(t) << TGS) | (32'(s) << IXS) | (32'(w) << 2);
  endfunction

  assign req_tag   = TW'(cif.dmemaddr >> TGS);
  assign req_ix    = IX'(cif.dmemaddr >> IXS);
  assign req_w     = BW'((cif.dmemaddr >> 2) & 32'(NWORDS - 1));
  assign req       = cif.dmemREN | cif.dmemWEN;
  assign w_last    = (w_q == BW'(NWORDS - 1));
  assign line_last = (fset_q == IX'(NSETS - 1)) && (fway_q == WW'(NWAYS - 1));
  assign fl_dirty  = valid_q[fset_q][fway_q] & dirty_q[fset_q][fway_q];

  // Tag lookup and victim choice: first invalid way, else the oldest way
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int i = 0; i < int'(NWAYS); i++) begin
      if (valid_q[req_ix][i] && (tag_q[req_ix][i] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(i);
      end
    end
    for (int i = 0; i < int'(NWAYS); i++) begin
      if (!vic_found && !valid_q[req_ix][i]) begin
        vic_found = 1'b1;
        vic_way   = WW'(i);
      end
    end
    if (!vic_found) begin
      for (int i = 0; i < int'(NWAYS); i++) begin
        if (age_q[req_ix][i] == AW'(NWAYS - 1)) vic_way = WW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and bus outputs
  always_comb begin
    state_n  = state;
    dhit_c   = 1'b0;
    dren_c   = 1'b0;
    dwen_c   = 1'b0;
    daddr_c  = '0;
    dstore_c = '0;
    case (state)
      IDLE: begin
        if (cif.halt) begin
          state_n = FLUSH;
        end else if (req) begin
          if (hit) begin
            dhit_c = 1'b1;
          end else if (valid_q[req_ix][vic_way] && dirty_q[req_ix][vic_way]) begin
            state_n = WB;
          end else begin
            state_n = FETCH;
          end
        end
      end
      WB: begin
        dwen_c   = 1'b1;
        daddr_c  = mk_addr(tag_q[req_ix][vic_q], req_ix, w_q);
        dstore_c = data_q[req_ix][vic_q][w_q];
        if (!cif.dwait && w_last) state_n = FETCH;
      end
      FETCH: begin
        dren_c  = 1'b1;
        daddr_c = mk_addr(req_tag, req_ix, w_q);
        if (!cif.dwait && w_last) state_n = IDLE;
      end
      FLUSH: begin
        if (fl_dirty) begin
          dwen_c   = 1'b1;
          daddr_c  = mk_addr(tag_q[fset_q][fway_q], fset_q, w_q);
          dstore_c = data_q[fset_q][fway_q][w_q];
          if (!cif.dwait && w_last && line_last) state_n = DONE;
        end else if (line_last) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Line storage, LRU ages, burst/flush counters and statistics
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < int'(NSETS); s++) begin
        for (int i = 0; i < int'(NWAYS); i++) begin
          valid_q[s][i] <= 1'b0;
          dirty_q[s][i] <= 1'b0;
          tag_q[s][i]   <= '0;
          age_q[s][i]   <= AW'(i);
          for (int k = 0; k < int'(NWORDS); k++) data_q[s][i][k] <= '0;
        end
      end
      w_q        <= '0;
      vic_q      <= '0;
      fset_q     <= '0;
      fway_q     <= '0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          refill_q <= 1'b0;
          if (cif.halt) begin
            w_q    <= '0;
            fset_q <= '0;
            fway_q <= '0;
          end else if (req) begin
            if (hit) begin
              if (cif.dmemWEN) begin
                data_q[req_ix][hit_way][req_w] <= cif.dmemstore;
                dirty_q[req_ix][hit_way]       <= 1'b1;
              end
              for (int i = 0; i < int'(NWAYS); i++) begin
                if (WW'(i) == hit_way)
                  age_q[req_ix][i] <= '0;
                else if (age_q[req_ix][i] < age_q[req_ix][hit_way])
                  age_q[req_ix][i] <= age_q[req_ix][i] + AW'(1);
              end
              if (!refill_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
              vic_q <= vic_way;
              w_q   <= '0;
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
          end
        end
        WB: begin
          if (!cif.dwait) begin
            if (w_last) begin
              w_q                    <= '0;
              dirty_q[req_ix][vic_q] <= 1'b0;
            end else begin
              w_q <= w_q + BW'(1);
            end
          end
        end
        FETCH: begin
          if (!cif.dwait) begin
            data_q[req_ix][vic_q][w_q] <= cif.dload;
            if (w_last) begin
              w_q                    <= '0;
              valid_q[req_ix][vic_q] <= 1'b1;
              dirty_q[req_ix][vic_q] <= 1'b0;
              tag_q[req_ix][vic_q]   <= req_tag;
              refill_q               <= 1'b1;
            end else begin
              w_q <= w_q + BW'(1);
            end
          end
        end
        FLUSH: begin
          if (!fl_dirty || (!cif.dwait && w_last)) begin
            w_q <= '0;
            if (fl_dirty) dirty_q[fset_q][fway_q] <= 1'b0;
            if (fway_q == WW'(NWAYS - 1)) begin
              fway_q <= '0;
              fset_q <= fset_q + IX'(1);
            end else begin
              fway_q <= fway_q + WW'(1);
            end
          end else if (!cif.dwait) begin
            w_q <= w_q + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cif.dhit       = dhit_c;
  assign cif.dmemload   = dhit_c ? data_q[req_ix][hit_way][req_w] : '0;
  assign cif.flushed    = (state == DONE);
  assign cif.hit_count  = hit_cnt_q;
  assign cif.miss_count = miss_cnt_q;
  assign cif.dREN       = dren_c;
  assign cif.dWEN       = dwen_c;
  assign cif.daddr      = daddr_c;
  assign cif.dstore     = dstore_c;
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: default geometry (a) and 4-way/4-word geometry (b).
module tb_dcache_nway;
  logic CLK = 1'b0;
  logic nrst_a;
  logic nrst_b;
  int   total = 0;
  int   bad   = 0;

  logic        lwen  [$];
  logic [31:0] laddr [$];
  logic [31:0] ldata [$];

  dcache_nway_if ifa ();
  dcache_nway_if ifb ();

  dcache_nway u_dut_a (.CLK(CLK), .nRST(nrst_a), .cif(ifa.slave));
  dcache_nway #(.NSETS(8), .NWAYS(4), .NWORDS(4)) u_dut_b (.CLK(CLK), .nRST(nrst_b), .cif(ifb.slave));

  // Memory image: every word reads as its address xor a fixed pattern
  assign ifa.dload = ifa.daddr ^ 32'hA5A5_0000;
  assign ifb.dload = ifb.daddr ^ 32'hA5A5_0000;

  always #5 CLK = ~CLK;

  task automatic drive(input int sel, input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic halt, input logic dw);
    if (sel == 0) begin
      ifa.dmemREN = ren; ifa.dmemWEN = wen; ifa.dmemaddr = addr;
      ifa.dmemstore = wdata; ifa.halt = halt; ifa.dwait = dw;
    end else begin
      ifb.dmemREN = ren; ifb.dmemWEN = wen; ifb.dmemaddr = addr;
      ifb.dmemstore = wdata; ifb.halt = halt; ifb.dwait = dw;
    end
  endtask

  // Hold one request until dhit (or budget), logging completed bus transfers
  task automatic do_req(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit slow, output logic [31:0] rdata, output int cycles, output bit ok,
                        output int unstable);
    logic        h, r, w;
    logic [31:0] a, d, ld, prev_a;
    logic        dw, prev_w, have_prev;
    int          stall;
    cycles = 0; ok = 1'b0; unstable = 0; stall = 0; have_prev = 1'b0; prev_w = 1'b0;
    prev_a = '0; rdata = '0;
    while (!ok && cycles < 200) begin
      @(negedge CLK);
      drive(sel, ~we, we, addr, wdata, 1'b0, 1'b0);
      #1;
      if (sel == 0) begin
        h = ifa.dhit; r = ifa.dREN; w = ifa.dWEN; a = ifa.daddr; d = ifa.dstore; ld = ifa.dmemload;
      end else begin
        h = ifb.dhit; r = ifb.dREN; w = ifb.dWEN; a = ifb.daddr; d = ifb.dstore; ld = ifb.dmemload;
      end
      cycles++;
      if (h) begin
        ok = 1'b1;
        rdata = ld;
      end
      if (r | w) begin
        if (have_prev && prev_w && (a !== prev_a)) unstable++;
        dw = slow && (stall < 3);
        stall = dw ? stall + 1 : 0;
        if (sel == 0) ifa.dwait = dw; else ifb.dwait = dw;
        if (!dw) begin
          lwen.push_back(w); laddr.push_back(a); ldata.push_back(d);
        end
        prev_w = dw; prev_a = a; have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
    @(negedge CLK);
    drive(sel, 1'b0, 1'b0, addr, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    lwen.delete(); laddr.delete(); ldata.delete();
  endtask

  task automatic test_reset();
    nrst_a = 1'b0; nrst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    #1;
    total++; if (ifa.dREN !== 1'b0 || ifa.dWEN !== 1'b0) begin bad++; $display("FAIL reset_bus: dREN=%b dWEN=%b want 0 0", ifa.dREN, ifa.dWEN); end
    total++; if (ifa.daddr !== 32'h0) begin bad++; $display("FAIL reset_daddr: got %h want 0", ifa.daddr); end
    total++; if (ifa.hit_count !== 32'h0 || ifa.miss_count !== 32'h0) begin bad++; $display("FAIL reset_counts: hit=%0d miss=%0d want 0 0", ifa.hit_count, ifa.miss_count); end
    total++; if (ifa.flushed !== 1'b0 || ifa.dhit !== 1'b0) begin bad++; $display("FAIL reset_flags: flushed=%b dhit=%b want 0 0", ifa.flushed, ifa.dhit); end
    @(negedge CLK);
    nrst_a = 1'b1; nrst_b = 1'b1;
    @(negedge CLK); #1;
    total++; if (ifa.dREN !== 1'b0 || ifb.dREN !== 1'b0) begin bad++; $display("FAIL idle_bus: a=%b b=%b want 0 0", ifa.dREN, ifb.dREN); end
  endtask

  task automatic test_load_miss();
    logic [31:0] rd; int cyc; bit ok; int un;
    clear_log();
    do_req(0, 1'b0, 32'h100, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 4) begin bad++; $display("FAIL miss_latency: ok=%b cycles=%0d want 1 4", ok, cyc); end
    total++; if (rd !== 32'hA5A5_0100) begin bad++; $display("FAIL miss_data: got %h want a5a50100", rd); end
    total++;
    if (laddr.size() != 2) begin bad++; $display("FAIL miss_burst_len: got %0d want 2", laddr.size()); end
    else if (laddr[0] !== 32'h100 || laddr[1] !== 32'h104 || lwen[0] !== 1'b0 || lwen[1] !== 1'b0) begin
      bad++; $display("FAIL miss_burst_addr: got %h %h want 00000100 00000104 reads", laddr[0], laddr[1]);
    end
    do_req(0, 1'b0, 32'h100, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 1) begin bad++; $display("FAIL hit_latency: ok=%b cycles=%0d want 1 1", ok, cyc); end
    total++; if (rd !== 32'hA5A5_0100) begin bad++; $display("FAIL hit_data: got %h want a5a50100", rd); end
    total++; if (ifa.hit_count !== 32'd1 || ifa.miss_count !== 32'd1) begin bad++; $display("FAIL counts_1: hit=%0d miss=%0d want 1 1", ifa.hit_count, ifa.miss_count); end
  endtask

  task automatic test_writeback();
    logic [31:0] rd; int cyc; bit ok; int un;
    do_req(0, 1'b0, 32'h200, 32'h0, 1'b0, rd, cyc, ok, un);
    do_req(0, 1'b1, 32'h204, 32'hDEAD_BEEF, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 1) begin bad++; $display("FAIL store_hit: ok=%b cycles=%0d want 1 1", ok, cyc); end
    do_req(0, 1'b0, 32'h404, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 4) begin bad++; $display("FAIL clean_evict_latency: cycles=%0d want 4", cyc); end
    clear_log();
    do_req(0, 1'b0, 32'h604, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 6) begin bad++; $display("FAIL dirty_evict_latency: cycles=%0d want 6", cyc); end
    total++; if (rd !== 32'hA5A5_0604) begin bad++; $display("FAIL evict_data: got %h want a5a50604", rd); end
    total++;
    if (laddr.size() != 4) begin bad++; $display("FAIL wb_len: got %0d want 4", laddr.size()); end
    else if (lwen[0] !== 1'b1 || laddr[0] !== 32'h200 || ldata[0] !== 32'hA5A5_0200 ||
             lwen[1] !== 1'b1 || laddr[1] !== 32'h204 || ldata[1] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL wb_words: got %b %h=%h %b %h=%h want 1 200=a5a50200 1 204=deadbeef",
                      lwen[0], laddr[0], ldata[0], lwen[1], laddr[1], ldata[1]);
    end else if (lwen[2] !== 1'b0 || laddr[2] !== 32'h600 || lwen[3] !== 1'b0 || laddr[3] !== 32'h604) begin
      bad++; $display("FAIL wb_then_fetch: got %b %h %b %h want 0 600 0 604", lwen[2], laddr[2], lwen[3], laddr[3]);
    end
    total++; if (ifa.hit_count !== 32'd2 || ifa.miss_count !== 32'd4) begin bad++; $display("FAIL counts_2: hit=%0d miss=%0d want 2 4", ifa.hit_count, ifa.miss_count); end
  endtask

  task automatic test_dwait();
    logic [31:0] rd; int cyc; bit ok; int un;
    clear_log();
    do_req(0, 1'b0, 32'h108, 32'h0, 1'b1, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 10) begin bad++; $display("FAIL stall_latency: ok=%b cycles=%0d want 1 10", ok, cyc); end
    total++; if (un !== 0) begin bad++; $display("FAIL stall_stable: changes=%0d want 0", un); end
    total++;
    if (laddr.size() != 2) begin bad++; $display("FAIL stall_len: got %0d want 2", laddr.size()); end
    else if (laddr[0] !== 32'h108 || laddr[1] !== 32'h10C) begin bad++; $display("FAIL stall_addr: got %h %h want 108 10c", laddr[0], laddr[1]); end
    total++; if (rd !== 32'hA5A5_0108) begin bad++; $display("FAIL stall_data: got %h want a5a50108", rd); end
  endtask

  task automatic test_flush();
    logic [31:0] rd; int cyc; bit ok; int un; int busy; int nren; bit done;
    do_req(0, 1'b1, 32'h108, 32'h1111_1111, 1'b0, rd, cyc, ok, un);
    do_req(0, 1'b0, 32'h028, 32'h0, 1'b0, rd, cyc, ok, un);
    do_req(0, 1'b1, 32'h12C, 32'h2222_2222, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 4) begin bad++; $display("FAIL store_miss_latency: cycles=%0d want 4", cyc); end
    total++; if (ifa.hit_count !== 32'd3 || ifa.miss_count !== 32'd7) begin bad++; $display("FAIL counts_3: hit=%0d miss=%0d want 3 7", ifa.hit_count, ifa.miss_count); end
    clear_log();
    @(negedge CLK);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
    #1;
    total++; if (ifa.dhit !== 1'b0) begin bad++; $display("FAIL halt_priority: dhit=%b want 0", ifa.dhit); end
    busy = 0; nren = 0; done = 1'b0;
    while (!done && busy < 100) begin
      @(negedge CLK);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      if (ifa.flushed) done = 1'b1;
      else begin
        busy++;
        if (ifa.dREN) nren++;
        if (ifa.dWEN) begin lwen.push_back(1'b1); laddr.push_back(ifa.daddr); ldata.push_back(ifa.dstore); end
      end
    end
    total++; if (!done || busy !== 18) begin bad++; $display("FAIL flush_cycles: done=%b cycles=%0d want 1 18", done, busy); end
    total++; if (nren !== 0) begin bad++; $display("FAIL flush_reads: got %0d want 0", nren); end
    total++;
    if (laddr.size() != 4) begin bad++; $display("FAIL flush_len: got %0d want 4", laddr.size()); end
    else if (laddr[0] !== 32'h108 || ldata[0] !== 32'h1111_1111 || laddr[1] !== 32'h10C || ldata[1] !== 32'hA5A5_010C ||
             laddr[2] !== 32'h128 || ldata[2] !== 32'hA5A5_0128 || laddr[3] !== 32'h12C || ldata[3] !== 32'h2222_2222) begin
      bad++; $display("FAIL flush_order: got %h=%h %h=%h %h=%h %h=%h want 108=11111111 10c=a5a5010c 128=a5a50128 12c=22222222",
                      laddr[0], ldata[0], laddr[1], ldata[1], laddr[2], ldata[2], laddr[3], ldata[3]);
    end
  endtask

  task automatic test_done();
    int hits; int bus; int unflushed;
    hits = 0; bus = 0; unflushed = 0;
    repeat (4) begin
      @(negedge CLK);
      drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
      #1;
      if (ifa.dhit) hits++;
      if (ifa.dREN || ifa.dWEN) bus++;
      if (!ifa.flushed) unflushed++;
    end
    @(negedge CLK);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++; if (hits !== 0) begin bad++; $display("FAIL done_no_hit: got %0d want 0", hits); end
    total++; if (bus !== 0 || unflushed !== 0) begin bad++; $display("FAIL done_sticky: bus=%0d unflushed=%0d want 0 0", bus, unflushed); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] rd; int cyc; bit ok; int un;
    @(negedge CLK); nrst_a = 1'b0;
    @(negedge CLK); nrst_a = 1'b1;
    #1;
    total++; if (ifa.flushed !== 1'b0) begin bad++; $display("FAIL reset_clears_flushed: got %b want 0", ifa.flushed); end
    @(negedge CLK);
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
    @(negedge CLK); #1;
    total++; if (ifa.dREN !== 1'b1 || ifa.daddr !== 32'h100) begin bad++; $display("FAIL mid_fetch: dREN=%b daddr=%h want 1 100", ifa.dREN, ifa.daddr); end
    nrst_a = 1'b0;
    #1;
    total++; if (ifa.dREN !== 1'b0 || ifa.miss_count !== 32'h0) begin bad++; $display("FAIL async_reset: dREN=%b miss=%0d want 0 0", ifa.dREN, ifa.miss_count); end
    @(negedge CLK);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    nrst_a = 1'b1;
    do_req(0, 1'b0, 32'h100, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 4) begin bad++; $display("FAIL post_reset_miss: cycles=%0d want 4", cyc); end
    total++; if (ifa.miss_count !== 32'd1 || ifa.hit_count !== 32'd0) begin bad++; $display("FAIL post_reset_counts: hit=%0d miss=%0d want 0 1", ifa.hit_count, ifa.miss_count); end
  endtask

  task automatic test_lru4();
    logic [31:0] rd; int cyc; bit ok; int un; int slow_fills;
    slow_fills = 0;
    for (int t = 1; t <= 5; t++) begin
      do_req(1, 1'b0, 32'(t) << 7, 32'h0, 1'b0, rd, cyc, ok, un);
      if (!ok || cyc != 6) slow_fills++;
    end
    total++; if (slow_fills !== 0) begin bad++; $display("FAIL lru4_fill: bad fills=%0d want 0", slow_fills); end
    clear_log();
    do_req(1, 1'b0, 32'h088, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 6 || rd !== 32'hA5A5_0088) begin bad++; $display("FAIL lru4_retouch: cycles=%0d data=%h want 6 a5a50088", cyc, rd); end
    total++;
    if (laddr.size() != 4) begin bad++; $display("FAIL lru4_burst_len: got %0d want 4", laddr.size()); end
    else if (laddr[0] !== 32'h080 || laddr[1] !== 32'h084 || laddr[2] !== 32'h088 || laddr[3] !== 32'h08C) begin
      bad++; $display("FAIL lru4_burst_addr: got %h %h %h %h want 080 084 088 08c", laddr[0], laddr[1], laddr[2], laddr[3]);
    end
    do_req(1, 1'b0, 32'h180, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 1) begin bad++; $display("FAIL lru4_tag3_kept: cycles=%0d want 1", cyc); end
    do_req(1, 1'b0, 32'h104, 32'h0, 1'b0, rd, cyc, ok, un);
    total++; if (!ok || cyc !== 6 || rd !== 32'hA5A5_0104) begin bad++; $display("FAIL lru4_tag2_evicted: cycles=%0d data=%h want 6 a5a50104", cyc, rd); end
    total++; if (ifb.hit_count !== 32'd1 || ifb.miss_count !== 32'd7) begin bad++; $display("FAIL lru4_counts: hit=%0d miss=%0d want 1 7", ifb.hit_count, ifb.miss_count); end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_writeback();
    test_dwait();
    test_flush();
    test_done();
    test_reset_mid_fetch();
    test_lru4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised write-back, write-allocate data cache between the datapath and the memory controller. Successor to the fixed 8-set, 2-way, 2-word dcache.
- Generalised in set count, associativity and block size, with true-LRU replacement.
- Adds same-cycle hit response, a hit/miss counter and a deterministic flush sequencer that ends in a sticky flushed flag.

Parameters:
- NSETS, 8, number of sets; power of 2, 2..64.
- NWAYS, 2, associativity; power of 2, 1..4.
- NWORDS, 2, 32-bit words per block; power of 2, 1..8.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dmemREN  in  1  datapath load request.
- dmemWEN  in  1  datapath store request.
- dmemaddr  in  32  byte address; bits[1:0] ignored.
- dmemstore  in  32  store data.
- halt  in  1  start flush.
- dhit  out  1  request completed this cycle.
- dmemload  out  32  load data, valid when dhit.
- flushed  out  1  flush complete, sticky.
- hit_count  out  32  number of requests that hit on first lookup.
- miss_count  out  32  number of misses.
- dwait  in  1  memory busy; a transfer completes in a cycle where dwait=0.
- dload  in  32  memory read data.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address, bits[1:0]=0.
- dstore  out  32  memory write data.

Behaviour:
- Address split, LSB first:
  - 2 byte-offset bits.
  - BO = log2(NWORDS) block-offset bits.
  - IX = log2(NSETS) index bits.
  - Tag = the remaining 30-BO-IX bits.
- Each line holds valid, dirty, tag, NWORDS data words and an LRU age of log2(NWAYS) bits. Age 0 = most recent.
- Reset values:
  - All lines invalid, clean, zero data, ages = way number.
  - State IDLE; counters 0; flushed 0.
  - All outputs 0.
  - A reset mid-burst abandons the burst without completing the memory transaction.
- Request = dmemREN|dmemWEN. When both are high, the request is a store.
- Hit = valid line in set with matching tag. Dirty lines still hit.
- States: IDLE, WB, FETCH, FLUSH, DONE.
- IDLE:
  - On a hit, dhit=1 combinationally in the same cycle.
  - Load hit: dmemload = the addressed word.
  - Store hit: the word is written and dirty set at the clock edge.
  - Any hit: the hit way's age becomes 0; ways younger than it age by 1; hit_count increments once per request. A request that hits only after a refill is not counted.
  - On a miss, the victim is the first invalid way (lowest index); if none, the way with age NWAYS-1. miss_count increments.
  - Next state is WB if the victim is valid and dirty, else FETCH.
- WB:
  - dWEN=1, daddr = {victim tag, index, word counter w, 00}, dstore = word w.
  - w advances on !dwait. After word NWORDS-1, clear dirty and go to FETCH.
- FETCH:
  - dREN=1, daddr = {request tag, index, w, 00}.
  - On !dwait, dload is stored into word w of the victim line.
  - After the last word, set valid, tag and clean; return to IDLE. The retried lookup then hits, with no hit_count increment.
- The datapath holds its request stable while dhit=0. The cache samples dmemaddr continuously.
- halt is sampled only in IDLE, with priority over a concurrent request; next state is FLUSH.
- FLUSH:
  - Scan order is set-major, then way, then word.
  - Dirty valid lines drive dWEN with their words and advance on !dwait.
  - Clean or invalid lines take one cycle each with no bus activity.
  - Request inputs and dhit are ignored and held 0.
- DONE: flushed=1 and no bus activity until reset.
- Degenerate cases:
  - NWAYS=1: age field is absent and the victim is the single way.
  - NWORDS=1: BO=0 and bursts are one word.
- Counters saturate at 0xFFFFFFFF.

Test Plan:
- Default params: load 0x100 (miss, dwait=0 throughout) → dREN to 0x100, then 0x104, then dhit with dload value; repeat load → dhit same cycle, hit_count=1, miss_count=1.
- Store 0xDEADBEEF to 0x204 after load miss to 0x200 → dirty line; loads from 0x404, then 0x604, to the same set (index 0) → evicts the LRU line 0x200; WB writes 0x200, then 0x204=0xDEADBEEF, before the FETCH of 0x600.
- NWAYS=4, NWORDS=4: fill five distinct tags into set 0, then re-touch tag 1 → victim is tag 2 (LRU); FETCH bursts of 4 words, addresses incrementing by 4.
- dwait held high 3 cycles per word → outputs stable, no word advance, no dhit until the burst completes.
- Two dirty lines (set 1 way 0, set 5 way 1), then halt → exactly 2×NWORDS dWEN transfers in scan order, then flushed=1 held; a later dmemREN gives no dhit.
- Assert nRST mid-FETCH → dREN=0 immediately; the next load of the same address misses (miss_count=1 after reset).
